ccsds123_sample_ctrl: RTL and testbench

CCSDS123_SAMPLE_CTRL -- requirements
Module: ccsds123_sample_ctrl

---
 rtl/ccsds123_pkg.sv | 25 ++
 rtl/ccsds123_coord_cnt.sv | 67 ++++++
 rtl/ccsds123_sample_ctrl.sv | 156 +++++++++++++++
 tb/tb_ccsds123_sample_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccsds123_pkg.sv
// Shared definitions for the CCSDS-123 sample controller.
//   state_e  : controller state encoding (RUN, DRAIN, DONE)
//   FLAG_*   : bit positions inside the 5-bit m_flags vector
//   coord_w  : width of a coordinate counter for a dimension of n entries
package ccsds123_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int NUM_FLAGS          = 5;
  localparam int FLAG_FIRST_LINE    = 0;
  localparam int FLAG_FIRST_IN_LINE = 1;
  localparam int FLAG_LAST_IN_LINE  = 2;
  localparam int FLAG_FIRST_BAND    = 3;
  localparam int FLAG_LAST          = 4;

  // A dimension of size 1 still gets a 1-bit coordinate that stays at 0.
  function automatic int coord_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ccsds123_coord_cnt.sv
// Three-level wrap counter holding the coordinate of the next sample to be
// accepted, in BIP order (z fastest, then x, then y).
//   clk, aresetn : clock, synchronous active-low reset
//   i_en         : advance to the next coordinate
//   o_x/o_y/o_z  : current coordinate
//   o_flags      : position flags of the current coordinate
module ccsds123_coord_cnt
  import ccsds123_pkg::*;
#(
  parameter int NX = 4,
  parameter int NY = 4,
  parameter int NZ = 16,
  localparam int XW = coord_w(NX),
  localparam int YW = coord_w(NY),
  localparam int ZW = coord_w(NZ)
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic                 i_en,
  output logic [XW-1:0]        o_x,
  output logic [YW-1:0]        o_y,
  output logic [ZW-1:0]        o_z,
  output logic [NUM_FLAGS-1:0] o_flags
);

  localparam logic [XW-1:0] X_MAX = XW'(NX - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(NY - 1);
  localparam logic [ZW-1:0] Z_MAX = ZW'(NZ - 1);

  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [ZW-1:0] r_z;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      r_x <= '0;
      r_y <= '0;
      r_z <= '0;
    end else if (i_en) begin
      if (r_z == Z_MAX) begin
        r_z <= '0;
        if (r_x == X_MAX) begin
          r_x <= '0;
          r_y <= (r_y == Y_MAX) ? '0 : r_y + YW'(1);
        end else begin
          r_x <= r_x + XW'(1);
        end
      end else begin
        r_z <= r_z + ZW'(1);
      end
    end
  end

  assign o_x = r_x;
  assign o_y = r_y;
  assign o_z = r_z;

  // With a dimension of 1 the MAX constant is 0, so first and last coincide.
  assign o_flags[FLAG_FIRST_LINE]    = (r_y == '0);
  assign o_flags[FLAG_FIRST_IN_LINE] = (r_x == '0);
  assign o_flags[FLAG_LAST_IN_LINE]  = (r_x == X_MAX);
  assign o_flags[FLAG_FIRST_BAND]    = (r_z == '0);
  assign o_flags[FLAG_LAST]          = (r_z == Z_MAX) && (r_x == X_MAX) && (r_y == Y_MAX);

endmodule

// File: rtl/ccsds123_sample_ctrl.sv
// Sample sequencer in front of a CCSDS-123 predictor. Accepts raw BIP samples,
// tags each with its (x,y,z) coordinate and position flags, presents them as a
// one-deep registered stream, then waits for the predictor pipeline to drain.
//   clk, aresetn                 : clock, synchronous active-low reset
//   s_axis_tdata/tvalid/tready   : raw sample input
//   m_ready/m_valid/m_sample     : tagged sample output
//   m_x, m_y, m_z, m_flags       : coordinate and flags of the beat on m_sample
//   busy                         : a frame is in progress (RUN after accept, DRAIN)
//   done                         : one-cycle end-of-image pulse
module ccsds123_sample_ctrl
  import ccsds123_pkg::*;
#(
  parameter int NX    = 4,
  parameter int NY    = 4,
  parameter int NZ    = 16,
  parameter int D     = 8,
  parameter int DRAIN = 6,
  localparam int XW = coord_w(NX),
  localparam int YW = coord_w(NY),
  localparam int ZW = coord_w(NZ)
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic [D-1:0]         s_axis_tdata,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 m_ready,
  output logic                 m_valid,
  output logic [D-1:0]         m_sample,
  output logic [XW-1:0]        m_x,
  output logic [YW-1:0]        m_y,
  output logic [ZW-1:0]        m_z,
  output logic [NUM_FLAGS-1:0] m_flags,
  output logic                 busy,
  output logic                 done
);

  localparam int DCW = coord_w(DRAIN);

  state_e               r_state, w_state_nxt;
  logic [DCW-1:0]       r_drain_cnt, w_drain_nxt;
  logic                 r_active;     // low while in reset, keeps tready low then
  logic                 r_last_acc;   // final sample of the image already taken
  logic                 r_started;    // at least one sample of this frame taken
  logic                 r_valid;
  logic [D-1:0]         r_sample;
  logic [XW-1:0]        r_x;
  logic [YW-1:0]        r_y;
  logic [ZW-1:0]        r_z;
  logic [NUM_FLAGS-1:0] r_flags;

  logic [XW-1:0]        w_x;
  logic [YW-1:0]        w_y;
  logic [ZW-1:0]        w_z;
  logic [NUM_FLAGS-1:0] w_flags;
  logic                 w_accept;
  logic                 w_xfer_last;

  // Depends only on registered state and m_ready, never on tvalid.
  assign s_axis_tready = r_active && (r_state == ST_RUN) && !r_last_acc
                         && (!r_valid || m_ready);
  assign w_accept      = s_axis_tvalid && s_axis_tready;
  assign w_xfer_last   = r_valid && m_ready && r_flags[FLAG_LAST];

  ccsds123_coord_cnt #(
    .NX (NX),
    .NY (NY),
    .NZ (NZ)
  ) u_coord (
    .clk     (clk),
    .aresetn (aresetn),
    .i_en    (w_accept),
    .o_x     (w_x),
    .o_y     (w_y),
    .o_z     (w_z),
    .o_flags (w_flags)
  );

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_drain_nxt = r_drain_cnt;
    done        = 1'b0;
    busy        = 1'b0;
    unique case (r_state)
      ST_RUN: begin
        busy = r_started;
        if (w_xfer_last) begin
          w_state_nxt = ST_DRAIN;
          w_drain_nxt = DCW'(DRAIN - 1);
        end
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (r_drain_cnt == '0) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_drain_nxt = r_drain_cnt - DCW'(1);
        end
      end
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // NOTE: the output register and its payload are reset too, so a frame
  // abandoned by reset leaves nothing stale on m_sample/m_x/m_y/m_z/m_flags.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      r_state     <= ST_RUN;
      r_drain_cnt <= '0;
      r_active    <= 1'b0;
      r_last_acc  <= 1'b0;
      r_started   <= 1'b0;
      r_valid     <= 1'b0;
      r_sample    <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_z         <= '0;
      r_flags     <= '0;
    end else begin
      r_active    <= 1'b1;
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_nxt;
      if (w_accept) begin
        // Also covers transfer-and-reload in the same cycle.
        r_valid   <= 1'b1;
        r_sample  <= s_axis_tdata;
        r_x       <= w_x;
        r_y       <= w_y;
        r_z       <= w_z;
        r_flags   <= w_flags;
        r_started <= 1'b1;
        if (w_flags[FLAG_LAST]) r_last_acc <= 1'b1;
      end else if (m_ready) begin
        r_valid <= 1'b0;
      end
      if (r_state == ST_DONE) begin
        r_last_acc <= 1'b0;
        r_started  <= 1'b0;
      end
    end
  end

  assign m_valid  = r_valid;
  assign m_sample = r_sample;
  assign m_x      = r_x;
  assign m_y      = r_y;
  assign m_z      = r_z;
  assign m_flags  = r_flags;

endmodule

// File: tb/tb_ccsds123_sample_ctrl.sv
// Directed bench for ccsds123_sample_ctrl: a 2x2x3 instance for streaming,
// stall, toggle and back-to-back frames, a default-size instance for
// mid-frame reset, and a 1x1x1 instance for the degenerate image.
module tb_ccsds123_sample_ctrl;

  localparam int DRN = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // 2x2x3 instance
  logic       a_rstn, a_tvalid, a_tready, a_mready, a_mvalid, a_done, a_busy;
  logic [7:0] a_tdata, a_msample;
  logic       a_mx, a_my;
  logic [1:0] a_mz;
  logic [4:0] a_mflags;

  // default 4x4x16 instance
  logic       d_rstn, d_tvalid, d_tready, d_mready, d_mvalid, d_done, d_busy;
  logic [7:0] d_tdata, d_msample;
  logic [1:0] d_mx, d_my;
  logic [3:0] d_mz;
  logic [4:0] d_mflags;

  // 1x1x1 instance
  logic       u_rstn, u_tvalid, u_tready, u_mready, u_mvalid, u_done, u_busy;
  logic [7:0] u_tdata, u_msample;
  logic       u_mx, u_my, u_mz;
  logic [4:0] u_mflags;

  ccsds123_sample_ctrl #(.NX(2), .NY(2), .NZ(3), .D(8), .DRAIN(DRN)) dut_a (
    .clk(clk), .aresetn(a_rstn), .s_axis_tdata(a_tdata), .s_axis_tvalid(a_tvalid),
    .s_axis_tready(a_tready), .m_ready(a_mready), .m_valid(a_mvalid),
    .m_sample(a_msample), .m_x(a_mx), .m_y(a_my), .m_z(a_mz), .m_flags(a_mflags),
    .busy(a_busy), .done(a_done));

  ccsds123_sample_ctrl #(.NX(4), .NY(4), .NZ(16), .D(8), .DRAIN(DRN)) dut_d (
    .clk(clk), .aresetn(d_rstn), .s_axis_tdata(d_tdata), .s_axis_tvalid(d_tvalid),
    .s_axis_tready(d_tready), .m_ready(d_mready), .m_valid(d_mvalid),
    .m_sample(d_msample), .m_x(d_mx), .m_y(d_my), .m_z(d_mz), .m_flags(d_mflags),
    .busy(d_busy), .done(d_done));

  ccsds123_sample_ctrl #(.NX(1), .NY(1), .NZ(1), .D(8), .DRAIN(DRN)) dut_u (
    .clk(clk), .aresetn(u_rstn), .s_axis_tdata(u_tdata), .s_axis_tvalid(u_tvalid),
    .s_axis_tready(u_tready), .m_ready(u_mready), .m_valid(u_mvalid),
    .m_sample(u_msample), .m_x(u_mx), .m_y(u_my), .m_z(u_mz), .m_flags(u_mflags),
    .busy(u_busy), .done(u_done));

  // Hand-computed {y, x, z[1:0], flags[4:0]} for each sample index of the
  // 2x2x3 image; flags = {last, first_band, last_in_line, first_in_line, first_line}.
  localparam logic [8:0] A_TAB [12] = '{
    9'b0_0_00_01011, 9'b0_0_01_00011, 9'b0_0_10_00011,
    9'b0_1_00_01101, 9'b0_1_01_00101, 9'b0_1_10_00101,
    9'b1_0_00_01010, 9'b1_0_01_00010, 9'b1_0_10_00010,
    9'b1_1_00_01100, 9'b1_1_01_00100, 9'b1_1_10_10100
  };

  function automatic logic [3:0] get_ctl(input int sel);
    if (sel == 0) return {a_done, a_busy, a_tready, a_mvalid};
    return {u_done, u_busy, u_tready, u_mvalid};
  endfunction

  // Entered at #1 after the edge that accepted the final sample, with
  // m_ready high. Done pulses DRN+1 edges later, tready returns one edge after.
  task automatic drain_check(input int sel);
    logic [3:0] got, exp;
    for (int k = 0; k <= DRN + 2; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      got = get_ctl(sel);
      exp = {k == DRN + 1, k <= DRN, k == DRN + 2, k == 0};
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL drain%0d k=%0d: {done,busy,tready,m_valid} got %b expected %b",
                 sel, k, got, exp);
      end
    end
  endtask

  // Streams one 2x2x3 frame of values base+i into dut_a and checks every beat.
  task automatic stream_a(input logic [7:0] base, input bit toggle,
                          input int stall_at, input bit hold_valid);
    int i = 0;
    int cyc = 0;
    bit acc;
    logic [17:0] got, exp;
    a_mready = 1'b1;
    while (i < 12 && cyc < 100) begin
      a_tvalid = toggle ? (cyc[0] == 1'b0) : 1'b1;
      a_tdata  = 8'(base + 8'(i));
      @(negedge clk);
      acc = a_tvalid && a_tready;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        got = {a_mvalid, a_msample, a_my, a_mx, a_mz, a_mflags};
        exp = {1'b1, 8'(base + 8'(i)), A_TAB[i]};
        n_vec++;
        if (got !== exp) begin
          n_err++;
          $display("FAIL beat%0d base=%h: got %h expected %h", i, base, got, exp);
        end
        if (i == stall_at) begin
          a_mready = 1'b0;
          a_tvalid = 1'b1;
          a_tdata  = 8'(base + 8'(i + 1));
          for (int s = 0; s < 4; s++) begin
            if (s > 0) begin
              @(posedge clk); #1;
            end else begin
              #1;
            end
            n_vec++;
            if ({a_mvalid, a_msample, a_my, a_mx, a_mz, a_mflags, a_tready} !== {exp, 1'b0}) begin
              n_err++;
              $display("FAIL stall%0d: got %h/%b expected %h/0", s,
                       {a_mvalid, a_msample, a_my, a_mx, a_mz, a_mflags}, a_tready, exp);
            end
          end
          a_mready = 1'b1;
        end
        i++;
      end else if (toggle) begin
        n_vec++;
        if (a_mvalid !== 1'b0) begin
          n_err++;
          $display("FAIL idle_cycle%0d: m_valid got %b expected 0", cyc, a_mvalid);
        end
      end
    end
    if (i < 12) begin
      n_vec++;
      n_err++;
      $display("FAIL stream_timeout: accepted %0d expected 12", i);
    end
    a_tvalid = hold_valid;
    a_tdata  = 8'hEE;
  endtask

  // Streams n samples base+i into dut_d starting at (0,0,0), all in line 0, band i.
  task automatic stream_d(input int n, input logic [7:0] base);
    int i = 0;
    int cyc = 0;
    bit acc;
    logic [21:0] got, exp;
    d_mready = 1'b1;
    d_tvalid = 1'b1;
    while (i < n && cyc < 50) begin
      d_tdata = 8'(base + 8'(i));
      @(negedge clk);
      acc = d_tvalid && d_tready;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        got = {d_mvalid, d_msample, d_my, d_mx, d_mz, d_mflags};
        exp = {1'b1, 8'(base + 8'(i)), 2'd0, 2'd0, 4'(i), (i == 0) ? 5'b01011 : 5'b00011};
        n_vec++;
        if (got !== exp) begin
          n_err++;
          $display("FAIL dbeat%0d base=%h: got %h expected %h", i, base, got, exp);
        end
        i++;
      end
    end
    if (i < n) begin
      n_vec++;
      n_err++;
      $display("FAIL dstream_timeout: accepted %0d expected %0d", i, n);
    end
  endtask

  task automatic test_reset;
    a_rstn = 1'b0;
    a_tvalid = 1'b1;
    a_tdata = 8'h33;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({a_mvalid, a_msample, a_mx, a_my, a_mz, a_mflags, a_done, a_busy, a_tready} !== 21'd0) begin
      n_err++;
      $display("FAIL reset_state: got %h expected 0",
               {a_mvalid, a_msample, a_mx, a_my, a_mz, a_mflags, a_done, a_busy, a_tready});
    end
    a_rstn = 1'b1;
  endtask

  task automatic test_stream;
    stream_a(8'h00, 1'b0, -1, 1'b1);
    drain_check(0);
  endtask

  task automatic test_back_to_back_stall;
    stream_a(8'h00, 1'b0, 5, 1'b1);
    drain_check(0);
  endtask

  task automatic test_toggle;
    stream_a(8'h80, 1'b1, -1, 1'b0);
    drain_check(0);
  endtask

  task automatic test_reset_midframe;
    logic [24:0] got;
    d_rstn = 1'b1;
    stream_d(7, 8'h10);
    d_rstn = 1'b0;
    for (int r = 0; r < 2; r++) begin
      @(posedge clk); #1;
      got = {d_mvalid, d_msample, d_mx, d_my, d_mz, d_mflags, d_done, d_busy, d_tready};
      n_vec++;
      if (got !== 25'd0) begin
        n_err++;
        $display("FAIL midreset%0d: got %h expected 0", r, got);
      end
    end
    d_rstn = 1'b1;
    stream_d(2, 8'h77);
    d_tvalid = 1'b0;
  endtask

  task automatic test_single_sample;
    int cyc = 0;
    bit acc = 1'b0;
    logic [16:0] got;
    u_rstn   = 1'b1;
    u_mready = 1'b1;
    u_tvalid = 1'b1;
    u_tdata  = 8'hA5;
    while (!acc && cyc < 10) begin
      @(negedge clk);
      acc = u_tvalid && u_tready;
      @(posedge clk); #1;
      cyc++;
    end
    got = {u_mvalid, u_msample, u_mx, u_my, u_mz, u_mflags};
    n_vec++;
    if (got !== {1'b1, 8'hA5, 3'b000, 5'b11111}) begin
      n_err++;
      $display("FAIL unit_beat: got %h expected %h", got, {1'b1, 8'hA5, 3'b000, 5'b11111});
    end
    u_tdata = 8'h5A;
    drain_check(1);
    @(posedge clk); #1;
    got = {u_mvalid, u_msample, u_mx, u_my, u_mz, u_mflags};
    n_vec++;
    if (got !== {1'b1, 8'h5A, 3'b000, 5'b11111}) begin
      n_err++;
      $display("FAIL unit_second_frame: got %h expected %h", got, {1'b1, 8'h5A, 3'b000, 5'b11111});
    end
    u_tvalid = 1'b0;
  endtask

  initial begin
    a_rstn = 1'b0; a_tvalid = 1'b0; a_tdata = '0; a_mready = 1'b1;
    d_rstn = 1'b0; d_tvalid = 1'b0; d_tdata = '0; d_mready = 1'b1;
    u_rstn = 1'b0; u_tvalid = 1'b0; u_tdata = '0; u_mready = 1'b1;
    test_reset();
    test_stream();
    test_back_to_back_stall();
    test_toggle();
    test_reset_midframe();
    test_single_sample();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
